// File: rtl/rtc_alarm_ctrl.sv
// rtc_alarm_ctrl: prescaled real-time clock with 12/24-hour display, time load and N alarm channels.
// Optional feature macro RTC_SNOOZE_EN builds the per-channel SNOOZE state and minute countdown.
module rtc_alarm_ctrl #(
  parameter int CLK_DIV    = 50_000_000,
  parameter int N_ALARMS   = 4,
  parameter int SNOOZE_MIN = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mode24,
  input  logic                ld_valid,
  input  logic [4:0]          ld_h,
  input  logic [5:0]          ld_m,
  input  logic [5:0]          ld_s,
  output logic                ld_err,
  input  logic                al_wr,
  input  logic [2:0]          al_idx,
  input  logic [4:0]          al_h,
  input  logic [5:0]          al_m,
  input  logic                al_en,
  input  logic [N_ALARMS-1:0] ack,
  input  logic [N_ALARMS-1:0] snooze,
  output logic [4:0]          h,
  output logic [5:0]          m,
  output logic [5:0]          s,
  output logic                pm,
  output logic                tick,
  output logic [N_ALARMS-1:0] ringing
);

  localparam int              PC_W   = $clog2(CLK_DIV);
  localparam logic [PC_W-1:0] PC_MAX = PC_W'(CLK_DIV - 1);

`ifdef RTC_SNOOZE_EN
  typedef enum logic [1:0] {ST_IDLE, ST_RING, ST_SNOOZE} al_st_t;
`else
  typedef enum logic {ST_IDLE, ST_RING} al_st_t;
  logic w_unused;
  assign w_unused = ^snooze;
`endif

  logic [PC_W-1:0] r_pc;
  logic [4:0]      r_h24;
  logic [5:0]      r_m;
  logic [5:0]      r_s;
  logic            r_ld_err;

  logic [4:0]      r_al_h  [N_ALARMS];
  logic [5:0]      r_al_m  [N_ALARMS];
  logic            r_al_en [N_ALARMS];
  al_st_t          r_st    [N_ALARMS];
  logic [5:0]      r_cnt   [N_ALARMS];
  al_st_t          w_st_n  [N_ALARMS];
  logic [5:0]      w_cnt_n [N_ALARMS];

  logic       w_ld_ok;
  logic       w_tick;
  logic       w_adv;
  logic       w_roll;
  logic [5:0] w_nm;
  logic [4:0] w_nh;

  assign w_ld_ok = ld_valid && (ld_h <= 5'd23) && (ld_m <= 6'd59) && (ld_s <= 6'd59);
  assign w_tick  = (r_pc == PC_MAX);
  // An accepted load swallows a coincident tick.
  assign w_adv   = w_tick && !w_ld_ok;
  assign w_roll  = w_adv && (r_s == 6'd59);
  assign w_nm    = (r_m == 6'd59) ? 6'd0 : r_m + 6'd1;
  assign w_nh    = (r_m != 6'd59) ? r_h24 : ((r_h24 == 5'd23) ? 5'd0 : r_h24 + 5'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc     <= '0;
      r_h24    <= '0;
      r_m      <= '0;
      r_s      <= '0;
      r_ld_err <= 1'b0;
    end else begin
      r_ld_err <= ld_valid && !w_ld_ok;
      if (w_ld_ok) begin
        r_h24 <= ld_h;
        r_m   <= ld_m;
        r_s   <= ld_s;
        r_pc  <= '0;
      end else begin
        r_pc <= w_tick ? '0 : r_pc + 1'b1;
        if (w_tick) begin
          if (r_s == 6'd59) begin
            r_s   <= 6'd0;
            r_m   <= w_nm;
            r_h24 <= w_nh;
          end else begin
            r_s <= r_s + 6'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_ALARMS; i++) begin
        r_al_h[i]  <= '0;
        r_al_m[i]  <= '0;
        r_al_en[i] <= 1'b0;
        r_st[i]    <= ST_IDLE;
        r_cnt[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < N_ALARMS; i++) begin
        r_st[i]  <= w_st_n[i];
        r_cnt[i] <= w_cnt_n[i];
        if (al_wr && (al_idx == 3'(i))) begin
          r_al_h[i]  <= al_h;
          r_al_m[i]  <= al_m;
          r_al_en[i] <= al_en;
        end
      end
    end
  end

  // r_cnt counts minutes spent ringing, or minutes left while snoozing.
  always_comb begin
    for (int i = 0; i < N_ALARMS; i++) begin
      w_st_n[i]  = r_st[i];
      w_cnt_n[i] = r_cnt[i];
      if (al_wr && (al_idx == 3'(i))) begin
        w_st_n[i] = ST_IDLE;
      end else begin
        case (r_st[i])
          ST_IDLE: begin
            if (w_roll && r_al_en[i] && (r_al_h[i] == w_nh) && (r_al_m[i] == w_nm)) begin
              w_st_n[i]  = ST_RING;
              w_cnt_n[i] = 6'd0;
            end
          end
          ST_RING: begin
            if (ack[i]) begin
              w_st_n[i] = ST_IDLE;
`ifdef RTC_SNOOZE_EN
            end else if (snooze[i]) begin
              w_st_n[i]  = ST_SNOOZE;
              w_cnt_n[i] = 6'(SNOOZE_MIN);
`endif
            end else if (w_roll) begin
              if (r_cnt[i] == 6'd59) w_st_n[i] = ST_IDLE;
              else                   w_cnt_n[i] = r_cnt[i] + 6'd1;
            end
          end
`ifdef RTC_SNOOZE_EN
          ST_SNOOZE: begin
            if (ack[i]) begin
              w_st_n[i] = ST_IDLE;
            end else if (w_roll) begin
              if (r_cnt[i] == 6'd1) begin
                w_st_n[i]  = ST_RING;
                w_cnt_n[i] = 6'd0;
              end else begin
                w_cnt_n[i] = r_cnt[i] - 6'd1;
              end
            end
          end
`endif
          default: w_st_n[i] = ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    ringing = '0;
    for (int i = 0; i < N_ALARMS; i++) ringing[i] = (r_st[i] == ST_RING);
  end

  always_comb begin
    if (mode24)                h = r_h24;
    else if (r_h24 == 5'd0)    h = 5'd12;
    else if (r_h24 > 5'd12)    h = r_h24 - 5'd12;
    else                       h = r_h24;
  end

  assign m      = r_m;
  assign s      = r_s;
  assign pm     = (r_h24 >= 5'd12);
  assign tick   = w_tick;
  assign ld_err = r_ld_err;

endmodule

// File: tb/tb_rtc_alarm_ctrl.sv
// tb_rtc_alarm_ctrl: directed and random stimulus against a seconds-of-day behavioural model.
`timescale 1ns/1ps
module tb_rtc_alarm_ctrl;
  localparam int CLK_DIV = 4;
  localparam int N       = 4;
  localparam int SNZ_MIN = 5;
  localparam int IDLE = 0, RING = 1, SNZ = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         mode24 = 1'b1;
  logic         ld_valid = 1'b0;
  logic [4:0]   ld_h = '0;
  logic [5:0]   ld_m = '0, ld_s = '0;
  logic         ld_err;
  logic         al_wr = 1'b0;
  logic [2:0]   al_idx = '0;
  logic [4:0]   al_h = '0;
  logic [5:0]   al_m = '0;
  logic         al_en = 1'b0;
  logic [N-1:0] ack = '0, snooze = '0;
  logic [4:0]   h;
  logic [5:0]   m, s;
  logic         pm, tick;
  logic [N-1:0] ringing;

  always #5 clk = ~clk;

  rtc_alarm_ctrl #(.CLK_DIV(CLK_DIV), .N_ALARMS(N), .SNOOZE_MIN(SNZ_MIN)) dut (
    .clk(clk), .rst(rst), .mode24(mode24), .ld_valid(ld_valid), .ld_h(ld_h), .ld_m(ld_m),
    .ld_s(ld_s), .ld_err(ld_err), .al_wr(al_wr), .al_idx(al_idx), .al_h(al_h), .al_m(al_m),
    .al_en(al_en), .ack(ack), .snooze(snooze), .h(h), .m(m), .s(s), .pm(pm), .tick(tick),
    .ringing(ringing));

  int vec = 0, errs = 0;
  bit chk_en = 0;

  // Model: time of day in seconds, prescaler phase, and alarm deadlines measured in rollovers.
  int tsec = 0, pcm = 0, rolls = 0;
  bit lderr_m = 0;
  int st[N], ring_at[N], wake_at[N], alh[N], alm[N];
  bit alen[N];
  bit m_acc, m_tick, m_roll;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tsec = 0; pcm = 0; rolls = 0; lderr_m = 0;
      for (int i = 0; i < N; i++) begin
        st[i] = IDLE; alh[i] = 0; alm[i] = 0; alen[i] = 0; ring_at[i] = 0; wake_at[i] = 0;
      end
    end else begin
      m_acc   = ld_valid && ld_h <= 23 && ld_m <= 59 && ld_s <= 59;
      lderr_m = ld_valid && !m_acc;
      m_tick  = (pcm == CLK_DIV - 1);
      m_roll  = 0;
      if (m_acc) begin
        tsec = ld_h * 3600 + ld_m * 60 + ld_s;
        pcm  = 0;
      end else begin
        pcm = m_tick ? 0 : pcm + 1;
        if (m_tick) begin
          m_roll = (tsec % 60 == 59);
          tsec   = (tsec + 1) % 86400;
        end
      end
      if (m_roll) rolls++;
      for (int i = 0; i < N; i++) begin
        if (al_wr && al_idx == i) begin
          alh[i] = al_h; alm[i] = al_m; alen[i] = al_en; st[i] = IDLE;
        end else if (st[i] == IDLE) begin
          if (m_roll && alen[i] && tsec / 3600 == alh[i] && (tsec / 60) % 60 == alm[i]) begin
            st[i] = RING; ring_at[i] = rolls;
          end
        end else if (st[i] == RING) begin
          if (ack[i]) st[i] = IDLE;
`ifdef RTC_SNOOZE_EN
          else if (snooze[i]) begin st[i] = SNZ; wake_at[i] = rolls + SNZ_MIN; end
`endif
          else if (rolls - ring_at[i] >= 60) st[i] = IDLE;
        end else begin
          if (ack[i]) st[i] = IDLE;
          else if (rolls == wake_at[i]) begin st[i] = RING; ring_at[i] = rolls; end
        end
      end
    end
  end

  always @(negedge clk) begin
    int hh;
    logic [4:0] eh;
    logic [N-1:0] er;
    if (chk_en && !rst) begin
      hh = tsec / 3600;
      eh = mode24 ? 5'(hh) : 5'((hh % 12 == 0) ? 12 : hh % 12);
      for (int i = 0; i < N; i++) er[i] = (st[i] == RING);
      cmp("h", 32'(h), 32'(eh));
      cmp("m", 32'(m), 32'((tsec / 60) % 60));
      cmp("s", 32'(s), 32'(tsec % 60));
      cmp("pm", 32'(pm), 32'(hh >= 12));
      cmp("tick", 32'(tick), 32'(pcm == CLK_DIV - 1));
      cmp("ld_err", 32'(ld_err), 32'(lderr_m));
      cmp("ringing", 32'(ringing), 32'(er));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input int hh, input int mm, input int ss);
    ld_valid = 1; ld_h = 5'(hh); ld_m = 6'(mm); ld_s = 6'(ss);
    step(1);
    ld_valid = 0;
  endtask

  task automatic wr(input int idx, input int hh, input int mm, input bit en);
    al_wr = 1; al_idx = 3'(idx); al_h = 5'(hh); al_m = 6'(mm); al_en = en;
    step(1);
    al_wr = 0;
  endtask

  task automatic pulse_ack(input int idx);
    ack = '0; ack[idx] = 1'b1;
    step(1);
    ack = '0;
  endtask

  initial begin
    step(2);
    cmp("rst_h", 32'(h), 0); cmp("rst_m", 32'(m), 0); cmp("rst_s", 32'(s), 0);
    cmp("rst_tick", 32'(tick), 0); cmp("rst_ringing", 32'(ringing), 0); cmp("rst_ld_err", 32'(ld_err), 0);
    rst = 0; chk_en = 1;

    // Midnight rollover
    load(23, 59, 58);
    cmp("roll_s58", 32'(s), 58); cmp("roll_pm1", 32'(pm), 1); cmp("roll_tick0", 32'(tick), 0);
    step(3); cmp("roll_tick1", 32'(tick), 1);
    step(1); cmp("roll_s59", 32'(s), 59);
    step(4);
    cmp("roll_h", 32'(h), 0); cmp("roll_m", 32'(m), 0); cmp("roll_s", 32'(s), 0);
    cmp("roll_pm0", 32'(pm), 0); cmp("model_tsec", 32'(tsec), 0);

    // 12-hour mapping
    mode24 = 0;
    load(0, 0, 0);  cmp("h12_0", 32'(h), 12); cmp("pm_0", 32'(pm), 0);
    load(12, 0, 0); cmp("h12_12", 32'(h), 12); cmp("pm_12", 32'(pm), 1);
    load(13, 5, 0); cmp("h12_13", 32'(h), 1); cmp("pm_13", 32'(pm), 1); cmp("m_13", 32'(m), 5);

    // Rejected loads
    load(24, 0, 0);
    cmp("rej_err", 32'(ld_err), 1); cmp("rej_h", 32'(h), 1); cmp("rej_m", 32'(m), 5);
    step(1); cmp("rej_err_fall", 32'(ld_err), 0);
    load(10, 60, 0);
    cmp("rej2_err", 32'(ld_err), 1); cmp("rej2_m", 32'(m), 5);

    // Load coincident with a tick
    mode24 = 1;
    load(8, 0, 0);
    step(3); cmp("coin_tick", 32'(tick), 1);
    load(9, 10, 20);
    cmp("coin_h", 32'(h), 9); cmp("coin_s", 32'(s), 20);
    step(3); cmp("coin_tick2", 32'(tick), 1); cmp("coin_s_hold", 32'(s), 20);
    step(1); cmp("coin_s21", 32'(s), 21);

    // Alarm match and ack
    wr(1, 7, 30, 1);
    load(7, 29, 59);
    step(3); cmp("al_pre", 32'(ringing), 0);
    step(1); cmp("al_ring", 32'(ringing), 4'b0010); cmp("al_m30", 32'(m), 30);
    pulse_ack(1); cmp("al_ack", 32'(ringing), 0);
    load(7, 30, 0);
    step(4); cmp("al_noload", 32'(ringing), 0);

    // Snooze
    wr(1, 7, 30, 0);
    wr(0, 7, 30, 1);
    load(7, 29, 59);
    step(4); cmp("sn_ring", 32'(ringing), 4'b0001);
    snooze = 4'b0001; step(1); snooze = '0;
`ifdef RTC_SNOOZE_EN
    cmp("sn_quiet", 32'(ringing), 0);
    step(1198); cmp("sn_still", 32'(ringing), 0); cmp("sn_m34", 32'(m), 34);
    step(1); cmp("sn_again", 32'(ringing), 4'b0001); cmp("sn_m35", 32'(m), 35); cmp("sn_s0", 32'(s), 0);
`else
    cmp("sn_ignored", 32'(ringing), 4'b0001);
`endif
    pulse_ack(0); cmp("sn_ack", 32'(ringing), 0);

    // Multi-channel, then asynchronous reset mid-ring
    wr(0, 6, 0, 1);
    wr(2, 6, 0, 1);
    load(5, 59, 59);
    step(4); cmp("multi", 32'(ringing), 4'b0101);
    #2 rst = 1;
    #1 cmp("arst_ring", 32'(ringing), 0); cmp("arst_h", 32'(h), 0);
    cmp("arst_m", 32'(m), 0); cmp("arst_s", 32'(s), 0);
    rst = 0;
    step(1);

    // Ring timeout after 60 minutes
    wr(3, 0, 1, 1);
    load(0, 0, 59);
    step(4); cmp("to_ring", 32'(ringing), 4'b1000);
    step(14399); cmp("to_hold", 32'(ringing), 4'b1000);
    step(1); cmp("to_clear", 32'(ringing), 0); cmp("to_h", 32'(h), 1); cmp("to_m", 32'(m), 1);

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      ld_valid = ($urandom % 60 == 0);
      ld_h = 5'($urandom % 26);
      ld_m = 6'($urandom % 62);
      ld_s = ($urandom % 2 == 0) ? 6'(54 + $urandom % 8) : 6'($urandom % 62);
      al_wr  = ($urandom % 40 == 0);
      al_idx = 3'($urandom % 8);
      al_h   = 5'(tsec / 3600);
      al_m   = 6'(((tsec / 60) % 60 + $urandom % 3) % 60);
      al_en  = ($urandom % 4 != 0);
      for (int i = 0; i < N; i++) begin
        ack[i]    = ($urandom % 50 == 0);
        snooze[i] = ($urandom % 30 == 0);
      end
      if ($urandom % 100 == 0) mode24 = ~mode24;
      step(1);
    end
    ld_valid = 0; al_wr = 0; ack = '0; snooze = '0;
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule

// File: doc/rtc_alarm_ctrl.md
# rtc_alarm_ctrl

Parametrised real-time clock with a programmable tick prescaler, 12/24-hour display mode, a synchronous time-load port and N independently armed alarm channels, each with its own ring/acknowledge state machine. It replaces the single-alarm free-running hour/minute/second counter as the timekeeping core. It feeds the display driver (time, PM flag) and the buzzer/interrupt logic (per-channel ring vector).

## Interface
- `CLK_DIV`, default 50_000_000: clk cycles per second; at least 2.
- `N_ALARMS`, default 4: number of alarm channels; 1–8.
- `SNOOZE_MIN`, default 5: snooze length in minutes; 1–59.
- `clk`  in  1: single clock.
- `rst`  in  1: asynchronous, active-high reset.
- `mode24`  in  1: 1 = 24-hour display, 0 = 12-hour display.
- `ld_valid`  in  1: time-load strobe, one cycle.
- `ld_h`  in  5, `ld_m`  in  6, `ld_s`  in  6: load values; hours are always in 24-hour form (0–23).
- `ld_err`  out  1: one-cycle pulse when a load is rejected.
- `al_wr`  in  1: alarm-register write strobe.
- `al_idx`  in  3: channel index; ignored if ≥ N_ALARMS.
- `al_h`  in  5, `al_m`  in  6, `al_en`  in  1: alarm time (24-hour form) and arm bit.
- `ack`  in  N_ALARMS: per-channel acknowledge pulse.
- `snooze`  in  N_ALARMS: per-channel snooze pulse.
- `h`  out  5, `m`  out  6, `s`  out  6: current time, hours formatted per `mode24`.
- `pm`  out  1: high for internal hours 12–23, in both modes.
- `tick`  out  1: one-cycle pulse on each second advance.
- `ringing`  out  N_ALARMS: per-channel ring indication.

## Operation
- Internal time is kept as h24 (0–23), m and s (0–59). The display mapping is combinational:
  - 24-hour mode: h = h24.
  - 12-hour mode: h = 12 when h24 is 0 or 12, otherwise h24 mod 12.
- Prescaler `pc` counts 0..CLK_DIV-1. `tick` is asserted while pc == CLK_DIV-1, and on that edge s advances.
- Carry chain:
  - s 59→0 increments m.
  - m 59→0 increments h24.
  - h24 23→0 wraps.
  - No value outside range is ever held.
- Load:
  - A load is accepted when ld_h ≤ 23, ld_m ≤ 59 and ld_s ≤ 59. It sets h24/m/s and clears pc to 0.
  - Any out-of-range field rejects the whole load: time is unchanged and `ld_err` pulses on the next cycle.
  - A load wins over a coincident tick; that tick is lost.
- Alarm registers, per channel: al_h, al_m, al_en; reset to 0:00, disarmed.
  - A write to a RING or SNOOZE channel also forces that channel to IDLE.
- Per-channel FSM, states IDLE, RING, SNOOZE:
  - IDLE→RING: on a tick that makes s go 59→0 where the new h24:m equals al_h:al_m and al_en = 1.
  - RING→IDLE: `ack`.
  - RING→SNOOZE: `snooze`. This loads a minute countdown with SNOOZE_MIN.
  - If `ack` and `snooze` arrive in the same cycle, `ack` wins.
  - SNOOZE: the countdown decrements on each minute rollover (s 59→0). SNOOZE→RING when it reaches 0 on a rollover.
  - SNOOZE→IDLE: `ack`.
  - RING auto-clears to IDLE after 60 minute rollovers without ack/snooze.
  - `ringing[i]` = (state == RING).
- Loads never trigger an alarm directly, even when the loaded time matches. Only a rollover into the matching minute does.
- Each channel is independent; several channels may ring at once.

## Timing
- Reset values: h24 = 0, m = 0, s = 0, pc = 0, tick = 0, ld_err = 0, ringing = 0; all FSMs IDLE.
- Reset is asynchronous and may be asserted mid-count or mid-ring. All state returns to the reset values immediately.
- Time outputs are registered:
  - After an accepted load in cycle t, h/m/s show the loaded value from cycle t+1.
  - The first subsequent tick occurs in cycle t+CLK_DIV.
- `tick` is combinational from pc. The time change is visible in the cycle after `tick`.
- `ringing` rises in the cycle after the matching rollover tick. It falls in the cycle after ack/snooze.
- `ack`/`snooze` with the channel not in an applicable state are ignored.
- A `mode24` change affects `h` in the same cycle; internal state is untouched.

## Configuration
- `RTC_SNOOZE_EN` defined: SNOOZE state, countdown logic and the `snooze` port behaviour are built as above.
- Not defined:
  - The `snooze` port remains but is ignored.
  - There is no SNOOZE state; RING leaves only via `ack`, an alarm-register write or the 60-minute timeout.

## Test plan
- Rollover: CLK_DIV = 4; load 23:59:58; run 8 cycles → tick every 4th cycle; h/m/s reach 00:00:00, pm falls 1→0.
- 12-hour mapping: load 0:00:00, 12:00:00 and 13:05:00 with mode24 = 0 → h = 12/pm 0, h = 12/pm 1, h = 1/pm 1.
- Load rejection: load 24:00:00 or 10:60:00 → ld_err pulses one cycle later, time unchanged. A load coincident with a tick → loaded value held, pc restarts at 0.
- Alarm match: ch1 armed at 07:30; load 07:29:59; next tick → ringing[1] = 1 one cycle after tick. Load 07:30:00 directly → no ring. ack[1] → ringing drops next cycle.
- Snooze (RTC_SNOOZE_EN, SNOOZE_MIN = 5): ringing ch0 at 07:30, pulse snooze[0] → ringing 0; it rings again at 07:35:00. Without the macro, snooze is ignored and ringing stays 1.
- Multi-channel and reset: ch0 and ch2 both at 06:00 → both ring together. Assert rst mid-ring → ringing = 0 and time = 0:00:00 asynchronously.
